seg_scan_driver: RTL and testbench
==================================

Name: seg_scan_driver

Overview:
- Parametrised multiplexed seven-segment driver; successor to the fixed 8-digit scan display.
- Adds: DIGITS-wide anode bus, tear-free double-buffered display data, per-digit decimal points, leading-zero blanking and PWM brightness.
- Sits between CPU-side status/register outputs and the board SEG/AN pins.
- All outputs are registered and active low.

Parameters:
- DIGITS, 8, number of digits scanned; legal range 2..16.
- SCAN_DIV, 75000, clk cycles per digit slot; must be at least 16. Benches use 16.
- BRIGHT_W, 4, width of the brightness input.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active high.
- load  in  1  capture data_in, dp_in and blank_lz into the pending buffer.
- data_in  in  4*DIGITS  hex nibbles; nibble DIGITS-1 is the leftmost digit.
- dp_in  in  DIGITS  decimal-point enables; bit k belongs to nibble k.
- blank_lz  in  1  enable leading-zero blanking.
- bright  in  BRIGHT_W  brightness level; 0 = dimmest, all-ones = full.
- SEG  out  8  {DP,G,F,E,D,C,B,A}, active low.
- AN  out  DIGITS  anode selects, active low; AN[DIGITS-1] is the leftmost digit.
- frame_start  out  1  one-cycle pulse when slot 0 begins.

Behaviour:
- Reset (rst=1 at a clk edge):
  - SEG=all ones, AN=all ones, frame_start=0.
  - prescaler=0, slot=0.
  - pending and active buffers cleared (data 0, dp 0, blank_lz 0).
  - rst overrides every other input, including a same-cycle load.
- Prescaler: counts 0..SCAN_DIV-1 and wraps to 0. Each wrap advances slot.
- Slot:
  - Counts 0..DIGITS-1 and wraps to 0; wrap is correct for non-power-of-2 DIGITS.
  - Slot s selects nibble DIGITS-1-s and anode AN[DIGITS-1-s], so slot 0 is the leftmost digit.
- Buffering:
  - On load=1, pending <= {data_in, dp_in, blank_lz} on that clk edge.
  - pending is copied to active on the edge where slot wraps DIGITS-1 -> 0. frame_start pulses on that same edge.
  - A load in the same cycle as the wrap is copied, so it is visible in the new frame.
  - A load at any other time becomes visible at the next frame start. No digit ever shows a mix of old and new data.
- Decode, using the same active-low patterns as the existing pattern table:
  - 0 -> C0, 1 -> F9, 2 -> A4, 3 -> B0, 4 -> 99, 5 -> 92, 6 -> 82, 7 -> F8
  - 8 -> 80, 9 -> 98, A -> 88, b -> 83, C -> C6, d -> A1, E -> 86, F -> 8E
  - SEG[7] = ~dp of the selected digit.
- Leading-zero blanking (active.blank_lz=1):
  - A digit is blank if its nibble and every more-significant nibble are 0.
  - The rightmost digit (nibble 0) is never blanked.
  - A blank digit drives SEG segments [6:0] all ones. Its DP is still honoured.
- Brightness:
  - on_cnt = ((bright+1)*SCAN_DIV) >> BRIGHT_W, computed at full width with no overflow.
  - The selected anode is low only while prescaler < on_cnt; otherwise AN is all ones.
  - bright is sampled continuously; no buffering is needed.
- Latency: outputs are registered, so SEG/AN reflect the slot/prescaler state one cycle after it changes.
- Exactly zero or one AN bit is low at any time, and AN is never low during reset.

Decomposition:
- Shared package seg_pkg:
  - 16-entry SEG pattern constant array.
  - SEG_OFF constant (8'hFF).
  - clog2-based width helper for the slot counter.
- One natural sub-module: seg_hex_decode (combinational nibble+dp+blank -> SEG).
- Prescaler, slot counter, buffers and PWM compare stay in the top module.

Test Plan (DIGITS=8, SCAN_DIV=16, BRIGHT_W=4):
- Reset values: hold rst 3 cycles, then release. SEG=FF and AN=FF during reset; first AN=7F appears one cycle after release, and frame_start pulses every 128 cycles.
- Scan order: load 32'h0123_4567, bright=F, blank_lz=0. Next frame shows slot 0: AN=7F, SEG=C0 (digit 0), through slot 7: AN=FE, SEG=F8 (digit 7). Each slot lasts 16 cycles.
- Tear-free load: load 32'hFFFF_FFFF mid-frame at slot 3. The remainder of the frame still shows the old data; the next frame shows all 8E.
- Leading-zero blanking: load 32'h0000_0000 with blank_lz=1 and dp_in=8'h01. Slots 0-6 give SEG=FF; slot 7 gives SEG=40 (0 with DP lit).
- Brightness: bright=0 gives AN low for 1 of 16 cycles per slot; bright=7 gives 8 of 16. Check duty over a full frame.
- Reset and load collisions:
  - Assert rst mid-slot 4: outputs go to FF next edge and the buffers clear.
  - A load coincident with the wrap edge shows the new data in slot 0 of the new frame.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed seven-segment scan driver: the active-low
// glyph table, the blank pattern and the slot-counter width helper.
package seg_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Active-low {DP,G,F,E,D,C,B,A} glyphs for 0..F (DP bit left dark).
    localparam logic [7:0] SEG_TABLE [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h98, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    function automatic int slot_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational nibble-to-segment decode with decimal point and blanking.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       dp_i,
    input  logic       blank_i,
    output logic [7:0] seg_o
);

    always_comb begin
        seg_o[7]   = ~dp_i;
        seg_o[6:0] = blank_i ? SEG_OFF[6:0] : SEG_TABLE[nibble_i][6:0];
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scanner: prescaler, slot counter, double-buffered
// display data, leading-zero blanking and PWM brightness on the anodes.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int DIGITS   = 8,
    parameter int SCAN_DIV = 75000,
    parameter int BRIGHT_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  blank_lz,
    input  logic [BRIGHT_W-1:0]   bright,
    output logic [7:0]            SEG,
    output logic [DIGITS-1:0]     AN,
    output logic                  frame_start
);

    localparam int SLOT_W  = slot_width(DIGITS);
    localparam int PRESC_W = $clog2(SCAN_DIV);
    localparam int ON_W    = BRIGHT_W + 1 + $clog2(SCAN_DIV + 1);

    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(SCAN_DIV - 1);
    localparam logic [SLOT_W-1:0]  SLOT_MAX  = SLOT_W'(DIGITS - 1);

    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [4*DIGITS-1:0] pend_data_q, pend_data_d, act_data_q, act_data_d;
    logic [DIGITS-1:0]   pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
    logic                pend_blz_q, pend_blz_d, act_blz_q, act_blz_d;
    logic [7:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic                frame_q;

    logic                presc_wrap, frame_wrap;
    logic [SLOT_W-1:0]   sel;
    logic [ON_W-1:0]     on_cnt;
    logic                lit;
    logic [DIGITS-1:0]   nib_zero;
    logic [DIGITS-1:0]   lz_mask;
    logic                zero_run;
    logic                digit_blank;

    assign presc_wrap = (presc_q == PRESC_MAX);
    assign frame_wrap = presc_wrap && (slot_q == SLOT_MAX);
    assign sel        = SLOT_MAX - slot_q;

    always_comb begin
        presc_d = presc_wrap ? '0 : presc_q + 1'b1;
        slot_d  = slot_q;
        if (presc_wrap) begin
            slot_d = (slot_q == SLOT_MAX) ? '0 : slot_q + 1'b1;
        end
    end

    // Active copies from pending_d so a load on the wrap edge lands in the new frame.
    always_comb begin
        pend_data_d = pend_data_q;
        pend_dp_d   = pend_dp_q;
        pend_blz_d  = pend_blz_q;
        if (load) begin
            pend_data_d = data_in;
            pend_dp_d   = dp_in;
            pend_blz_d  = blank_lz;
        end
        act_data_d = act_data_q;
        act_dp_d   = act_dp_q;
        act_blz_d  = act_blz_q;
        if (frame_wrap) begin
            act_data_d = pend_data_d;
            act_dp_d   = pend_dp_d;
            act_blz_d  = pend_blz_d;
        end
    end

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib_zero
        assign nib_zero[gi] = (act_data_q[4*gi +: 4] == 4'd0);
    end

    // lz_mask[k]: nibble k and every nibble to its left are zero; nibble 0 never blanks.
    always_comb begin
        zero_run   = 1'b1;
        lz_mask    = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run   = zero_run && nib_zero[i];
            lz_mask[i] = zero_run;
        end
    end

    assign digit_blank = act_blz_q && lz_mask[sel];

    always_comb begin
        on_cnt = (({{(ON_W-BRIGHT_W){1'b0}}, bright} + ON_W'(1)) * ON_W'(SCAN_DIV)) >> BRIGHT_W;
    end

    assign lit = ({{(ON_W-PRESC_W){1'b0}}, presc_q} < on_cnt);

    always_comb begin
        an_d = '1;
        if (lit) begin
            an_d[sel] = 1'b0;
        end
    end

    seg_hex_decode u_decode (
        .nibble_i (act_data_q[{sel, 2'b00} +: 4]),
        .dp_i     (act_dp_q[sel]),
        .blank_i  (digit_blank),
        .seg_o    (seg_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q     <= '0;
            slot_q      <= '0;
            pend_data_q <= '0;
            pend_dp_q   <= '0;
            pend_blz_q  <= 1'b0;
            act_data_q  <= '0;
            act_dp_q    <= '0;
            act_blz_q   <= 1'b0;
            seg_q       <= SEG_OFF;
            an_q        <= '1;
            frame_q     <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            slot_q      <= slot_d;
            pend_data_q <= pend_data_d;
            pend_dp_q   <= pend_dp_d;
            pend_blz_q  <= pend_blz_d;
            act_data_q  <= act_data_d;
            act_dp_q    <= act_dp_d;
            act_blz_q   <= act_blz_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
            frame_q     <= frame_wrap;
        end
    end

    assign SEG         = seg_q;
    assign AN          = an_q;
    assign frame_start = frame_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver (DIGITS=8, SCAN_DIV=16, BRIGHT_W=4):
// stimulus queues per-slot expectations, a monitor checks each displayed slot.
module tb_seg_scan_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [31:0] data_in;
    logic [7:0]  dp_in;
    logic        blank_lz;
    logic [3:0]  bright;
    logic [7:0]  SEG;
    logic [7:0]  AN;
    logic        frame_start;

    int total = 0;
    int bad   = 0;
    int frame_no = 0;

    typedef struct {
        int         frame;
        int         slot;
        logic [7:0] seg;
        logic [7:0] an;
        int         duty;
    } exp_t;

    exp_t sb[$];

    seg_scan_driver #(.DIGITS(8), .SCAN_DIV(16), .BRIGHT_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .data_in     (data_in),
        .dp_in       (dp_in),
        .blank_lz    (blank_lz),
        .bright      (bright),
        .SEG         (SEG),
        .AN          (AN),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // Frame k is being displayed once frame_no == k (counted from the last reset).
    always @(posedge clk) begin
        if (rst) frame_no <= 0;
        else if (frame_start) frame_no <= frame_no + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end else begin
            $display("check %s: %h ok", name, act);
        end
    endtask

    // segs packs slot 0 in the top byte down to slot 7 in the bottom byte.
    task automatic push_frame(input int fr, input logic [63:0] segs, input int duty);
        exp_t e;
        for (int s = 0; s < 8; s++) begin
            e.frame = fr;
            e.slot  = s;
            e.seg   = segs[63-8*s -: 8];
            e.an    = ~(8'h80 >> s);
            e.duty  = duty;
            sb.push_back(e);
        end
    endtask

    task automatic next_frame_start();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start && n < 300);
        check("frame_start_seen", {31'd0, frame_start}, 32'd1);
    endtask

    task automatic do_load(input logic [31:0] d, input logic [7:0] dp, input logic blz);
        data_in  = d;
        dp_in    = dp;
        blank_lz = blz;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
    endtask

    // Monitor: for every frame, observe each slot's 16 output cycles and compare
    // against the queued expectation for that (frame, slot), if any.
    initial begin : monitor
        bit         go;
        bit         have;
        bit         aborted;
        int         fr;
        int         hits;
        int         offs;
        logic [7:0] seg_s;
        exp_t       e;
        go = 1'b0;
        forever begin
            if (!go) begin
                @(negedge clk);
                go = frame_start && !rst;
            end else begin
                fr      = frame_no + 1;
                aborted = 1'b0;
                for (int s = 0; s < 8 && !aborted; s++) begin
                    have = 1'b0;
                    while (sb.size() > 0 &&
                           (sb[0].frame < fr || (sb[0].frame == fr && sb[0].slot < s))) begin
                        e = sb.pop_front();
                        total++;
                        bad++;
                        $display("FAIL slot_missed: frame %0d slot %0d never displayed (now frame %0d)",
                                 e.frame, e.slot, fr);
                    end
                    if (sb.size() > 0 && sb[0].frame == fr && sb[0].slot == s) begin
                        e    = sb.pop_front();
                        have = 1'b1;
                    end
                    hits  = 0;
                    offs  = 0;
                    seg_s = 8'hxx;
                    for (int c = 1; c <= 16; c++) begin
                        @(negedge clk);
                        if (rst) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (have && AN == e.an) hits++;
                        if (AN == 8'hFF) offs++;
                        if (c == 8) seg_s = SEG;
                    end
                    if (have && !aborted) begin
                        total++;
                        if (seg_s !== e.seg) begin
                            bad++;
                            $display("FAIL slot_seg f%0d s%0d: got %h required %h", fr, s, seg_s, e.seg);
                        end else begin
                            $display("slot f%0d s%0d seg %h ok", fr, s, seg_s);
                        end
                        total++;
                        if (hits != e.duty || offs != 16 - e.duty) begin
                            bad++;
                            $display("FAIL slot_duty f%0d s%0d: got on=%0d off=%0d required on=%0d off=%0d (an %h)",
                                     fr, s, hits, offs, e.duty, 16 - e.duty, e.an);
                        end else begin
                            $display("slot f%0d s%0d an %h on %0d/16 ok", fr, s, e.an, hits);
                        end
                    end
                end
                go = !aborted && frame_start;
            end
        end
    end

    initial begin : stimulus
        int n;
        rst      = 1'b1;
        load     = 1'b0;
        data_in  = 32'h0;
        dp_in    = 8'h0;
        blank_lz = 1'b0;
        bright   = 4'hF;

        // Reset values, first slot after release, frame period.
        repeat (3) @(negedge clk);
        check("reset_seg", {24'd0, SEG}, 32'hFF);
        check("reset_an", {24'd0, AN}, 32'hFF);
        check("reset_frame_start", {31'd0, frame_start}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("release_an", {24'd0, AN}, 32'h7F);
        check("release_seg", {24'd0, SEG}, 32'hC0);
        n = 1;
        while (!frame_start && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("first_frame_period", n, 128);

        // Frame 1 starts: load scan-order data for frame 2.
        push_frame(2, 64'hC0F9A4B0_999282F8, 16);
        do_load(32'h0123_4567, 8'h00, 1'b0);
        next_frame_start();

        // Frame 2: mid-frame load at slot 3 must wait for frame 3.
        push_frame(3, 64'h8E8E8E8E_8E8E8E8E, 16);
        repeat (16*3 + 4) @(negedge clk);
        do_load(32'hFFFF_FFFF, 8'h00, 1'b0);
        next_frame_start();

        // Frame 3: leading-zero blanking of all zeros with DP on the rightmost digit.
        push_frame(4, 64'hFFFFFFFF_FFFFFF40, 16);
        do_load(32'h0000_0000, 8'h01, 1'b1);
        next_frame_start();

        // Frame 4: brightness 0 over frame 5.
        push_frame(5, 64'hFFFFFFFF_FFFFFF40, 1);
        next_frame_start();
        bright = 4'h0;
        push_frame(6, 64'h00980883_C621860E, 8);
        do_load(32'h89AB_CDEF, 8'hA5, 1'b0);
        next_frame_start();
        bright = 4'h7;

        // Frame 6: load exactly on the wrap edge, interior zeros not blanked.
        push_frame(7, 64'hFFFFFFFF_B0C0F8C0, 16);
        repeat (127) @(negedge clk);
        data_in  = 32'h0000_3070;
        dp_in    = 8'h00;
        blank_lz = 1'b1;
        load     = 1'b1;
        @(negedge clk);
        check("wrap_period", {31'd0, frame_start}, 32'd1);
        load   = 1'b0;
        bright = 4'hF;
        next_frame_start();

        // Frame 8: reset mid-slot 4 clears outputs and both buffers.
        repeat (16*4 + 6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midreset_seg", {24'd0, SEG}, 32'hFF);
        check("midreset_an", {24'd0, AN}, 32'hFF);
        check("midreset_frame_start", {31'd0, frame_start}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        push_frame(1, 64'hC0C0C0C0_C0C0C0C0, 16);
        @(negedge clk);
        check("post_reset_an", {24'd0, AN}, 32'h7F);
        check("post_reset_seg", {24'd0, SEG}, 32'hC0);

        n = 0;
        while (sb.size() > 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
